// File: rtl/input_frame_deserializer.sv
// Purpose : deserialises one 3-wire serial frame into a parallel bus of signed Qm.n pixel words.
// Latency : final serialClock pin rise first sampled at edge k -> dataOut/dataValid update at edge k+2.
// Backpres: dataValid/dataReady handshake; a new frame overwrites an unaccepted one and sets sticky overrun.
//
// Ports:
//   clock, resetN                          system clock, async active-low reset
//   serialClock, serialData, serialEnable  asynchronous link inputs (sampled, never used as clocks)
//   dataReady                              consumer accepts the presented frame
//   dataOut, dataValid                     converted frame (pixel i at [dataWidth*i +: dataWidth]) and its valid
//   overrun                                sticky: an unaccepted frame was replaced
//   frameAbort                             one-cycle pulse when the envelope drops mid-frame
module input_frame_deserializer #(
    parameter int numInputs     = 784,
    parameter int bitsPerPixel  = 8,
    parameter int dataWidth     = 16,
    parameter int dataFracWidth = 8,
    parameter int dataIntWidth  = 8
) (
    input  logic                           clock,
    input  logic                           resetN,
    input  logic                           serialClock,
    input  logic                           serialData,
    input  logic                           serialEnable,
    input  logic                           dataReady,
    output logic [numInputs*dataWidth-1:0] dataOut,
    output logic                           dataValid,
    output logic                           overrun,
    output logic                           frameAbort
);

    localparam int N   = numInputs;
    localparam int B   = bitsPerPixel;
    localparam int F   = dataFracWidth;
    localparam int WW  = dataIntWidth + dataFracWidth;
    localparam int SW  = N * B;
    localparam int BCW = (B > 1) ? $clog2(B) : 1;
    localparam int PCW = $clog2(N);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(B - 1);
    localparam logic [PCW-1:0] PIX_LAST = PCW'(N - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Synchroniser bit order: {serialClock, serialEnable, serialData}.
    logic [2:0]               sync_s1_q, sync_s1_d;
    logic [2:0]               sync_s2_q, sync_s2_d;
    // History of {clock, enable}; data needs no edge detection.
    logic [1:0]               hist_q, hist_d;
    state_t                   state_q, state_d;
    logic [BCW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [PCW-1:0]           pix_cnt_q, pix_cnt_d;
    logic [SW-1:0]            shift_q, shift_d;
    logic [N*dataWidth-1:0]   dout_q, dout_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;
    logic                     abort_q, abort_d;

    logic                     sclk_rise, en_rise, en_fall, sdat;
    logic                     frame_done;
    logic [SW-1:0]            shift_in;
    logic [N*dataWidth-1:0]   frame_conv;
    logic [B-1:0]             pix;
    logic [WW-1:0]            word;

    always_comb begin
        sync_s1_d = {serialClock, serialEnable, serialData};
        sync_s2_d = sync_s1_q;
        hist_d    = sync_s2_q[2:1];
    end

    assign sclk_rise = sync_s2_q[2] & ~hist_q[1];
    assign en_rise   = sync_s2_q[1] & ~hist_q[0];
    assign en_fall   = ~sync_s2_q[1] & hist_q[0];
    assign sdat      = sync_s2_q[0];

    // New bits enter at the LSB, so the last pixel received lands at index 0.
    assign shift_in = {shift_q[SW-2:0], sdat};

    // Full-scale pixel maps to exactly 1.0; everything else is p scaled into the fraction.
    always_comb begin
        frame_conv = '0;
        pix        = '0;
        word       = '0;
        for (int i = 0; i < N; i++) begin
            pix  = shift_in[B*i +: B];
            word = '0;
            if (pix == {B{1'b1}}) begin
                word[F] = 1'b1;
            end else begin
                word[F-B +: B] = pix;
            end
            frame_conv[dataWidth*i +: dataWidth] = word;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        shift_d    = shift_q;
        dout_d     = dout_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        abort_d    = 1'b0;
        frame_done = 1'b0;

        if (valid_q && dataReady) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (en_rise) begin
                    bit_cnt_d = '0;
                    pix_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    shift_d = shift_in;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (pix_cnt_q == PIX_LAST) begin
                            frame_done = 1'b1;
                            state_d    = DONE;
                        end else begin
                            pix_cnt_d = pix_cnt_q + 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                // Completion wins over an envelope drop seen in the same cycle.
                if (en_fall && !frame_done) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (en_fall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_done) begin
            dout_d  = frame_conv;
            valid_d = 1'b1;
            if (valid_q && !dataReady) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            sync_s1_q <= '0;
            sync_s2_q <= '0;
            hist_q    <= '0;
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            pix_cnt_q <= '0;
            shift_q   <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            sync_s1_q <= sync_s1_d;
            sync_s2_q <= sync_s2_d;
            hist_q    <= hist_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            pix_cnt_q <= pix_cnt_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            abort_q   <= abort_d;
        end
    end

    assign dataOut    = dout_q;
    assign dataValid  = valid_q;
    assign overrun    = overrun_q;
    assign frameAbort = abort_q;

endmodule

// File: tb/tb_input_frame_deserializer.sv
module tb_input_frame_deserializer;

    logic         clock = 1'b0;
    logic         resetN = 1'b0;
    logic         sclk = 1'b0, sdat = 1'b0;
    logic         en_a = 1'b0, en_b = 1'b0;
    logic         rdy_a = 1'b0, rdy_b = 1'b0;
    logic [63:0]  dout_a;
    logic [127:0] dout_b;
    logic         valid_a, ov_a, abort_a;
    logic         valid_b, ov_b, abort_b;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [63:0]  d; logic ov; } exp_a_t;
    typedef struct { logic [127:0] d; logic ov; } exp_b_t;
    exp_a_t q_a[$];
    exp_b_t q_b[$];

    always #5 clock = ~clock;

    input_frame_deserializer #(.numInputs(4), .bitsPerPixel(8), .dataWidth(16),
                               .dataFracWidth(8), .dataIntWidth(8)) dut_a (
        .clock(clock), .resetN(resetN), .serialClock(sclk), .serialData(sdat),
        .serialEnable(en_a), .dataReady(rdy_a), .dataOut(dout_a), .dataValid(valid_a),
        .overrun(ov_a), .frameAbort(abort_a));

    input_frame_deserializer #(.numInputs(8), .bitsPerPixel(1), .dataWidth(16),
                               .dataFracWidth(8), .dataIntWidth(8)) dut_b (
        .clock(clock), .resetN(resetN), .serialClock(sclk), .serialData(sdat),
        .serialEnable(en_b), .dataReady(rdy_b), .dataOut(dout_b), .dataValid(valid_b),
        .overrun(ov_b), .frameAbort(abort_b));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: a frame is presented when valid rises or dataOut changes under valid.
    logic         pv_a = 1'b0, pv_b = 1'b0;
    logic [63:0]  pd_a = '0;
    logic [127:0] pd_b = '0;

    always @(negedge clock) begin
        if (valid_a && (!pv_a || dout_a != pd_a)) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_frame: got %h expected no new frame", dout_a);
            end else begin
                exp_a_t e;
                e = q_a.pop_front();
                chk("a_frame", dout_a, e.d);
                chk("a_overrun", ov_a, e.ov);
            end
        end
        pv_a = valid_a;
        pd_a = dout_a;
    end

    always @(negedge clock) begin
        if (valid_b && (!pv_b || dout_b != pd_b)) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_frame: got %h expected no new frame", dout_b);
            end else begin
                exp_b_t e;
                e = q_b.pop_front();
                chk("b_frame", dout_b, e.d);
                chk("b_overrun", ov_b, e.ov);
            end
        end
        pv_b = valid_b;
        pd_b = dout_b;
    end

    // Bits go MSB first; each serialClock phase lasts 4 system clocks.
    // pulse_last raises dataReady on the exact edge that loads the frame (k+2).
    task automatic send_bits(input logic [31:0] bits, input int n, input bit pulse_last);
        for (int i = n - 1; i >= 0; i--) begin
            sdat = bits[i];
            repeat (4) @(negedge clock);
            sclk = 1'b1;
            @(negedge clock);
            @(negedge clock);
            if (pulse_last && i == 0) rdy_a = 1'b1;
            @(negedge clock);
            rdy_a = 1'b0;
            @(negedge clock);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic set_en(input int which, input logic v);
        if (which == 0) en_a = v;
        else            en_b = v;
        repeat (6) @(negedge clock);
    endtask

    task automatic push_a(input logic [63:0] d, input logic ov);
        exp_a_t e;
        e.d  = d;
        e.ov = ov;
        q_a.push_back(e);
    endtask

    initial begin
        int ab;
        exp_b_t eb;
        repeat (3) @(negedge clock);
        chk("a_reset_dout", dout_a, 0);
        chk("a_reset_valid", valid_a, 0);
        chk("b_reset_dout", dout_b, 0);
        chk("b_reset_valid", valid_b, 0);
        resetN = 1'b1;
        repeat (3) @(negedge clock);
        chk("a_idle_overrun", ov_a, 0);
        chk("a_idle_abort", abort_a, 0);

        // Conversion incl. full-scale and zero pixels, no consumer.
        push_a(64'h0100_0080_0000_0001, 1'b0);
        set_en(0, 1'b1);
        send_bits(32'hFF80_0001, 32, 1'b0);

        // Extra serial clocks after completion are ignored.
        send_bits(32'h0000_001F, 5, 1'b0);
        chk("a_extra_dout", dout_a, 64'h0100_0080_0000_0001);
        chk("a_extra_valid", valid_a, 1);
        chk("a_extra_overrun", ov_a, 0);
        set_en(0, 1'b0);
        rdy_a = 1'b1;
        @(negedge clock);
        rdy_a = 1'b0;
        chk("a_accept_valid", valid_a, 0);

        // Envelope drop after 17 bits.
        set_en(0, 1'b1);
        send_bits(32'h0001_5A5A, 17, 1'b0);
        en_a = 1'b0;
        ab = 0;
        repeat (8) begin
            @(negedge clock);
            if (abort_a) ab++;
        end
        chk("a_abort_width", ab, 1);
        chk("a_abort_dout", dout_a, 64'h0100_0080_0000_0001);
        chk("a_abort_valid", valid_a, 0);

        push_a(64'h0012_0034_0056_0078, 1'b0);
        set_en(0, 1'b1);
        send_bits(32'h1234_5678, 32, 1'b0);
        set_en(0, 1'b0);

        // Second frame over an unaccepted one.
        push_a(64'h00AA_00BB_00CC_0100, 1'b1);
        set_en(0, 1'b1);
        send_bits(32'hAABB_CCFF, 32, 1'b0);
        set_en(0, 1'b0);

        // Reset in the middle of a frame.
        set_en(0, 1'b1);
        send_bits(32'h0000_03A5, 10, 1'b0);
        resetN = 1'b0;
        en_a   = 1'b0;
        @(negedge clock);
        chk("a_midreset_dout", dout_a, 0);
        chk("a_midreset_valid", valid_a, 0);
        chk("a_midreset_overrun", ov_a, 0);
        chk("a_midreset_abort", abort_a, 0);
        repeat (3) @(negedge clock);
        resetN = 1'b1;
        repeat (4) @(negedge clock);

        push_a(64'h0001_0002_0003_0004, 1'b0);
        set_en(0, 1'b1);
        send_bits(32'h0102_0304, 32, 1'b0);
        set_en(0, 1'b0);

        // Accept lands on the very edge that loads the next frame.
        push_a(64'h00FE_007F_0080_0100, 1'b0);
        set_en(0, 1'b1);
        send_bits(32'hFE7F_80FF, 32, 1'b1);
        chk("a_sameedge_valid", valid_a, 1);
        chk("a_sameedge_overrun", ov_a, 0);
        set_en(0, 1'b0);

        // 1-bit pixels: 1,0,1,1,0,0,0,1.
        eb.d  = 128'h0100_0000_0100_0100_0000_0000_0000_0100;
        eb.ov = 1'b0;
        q_b.push_back(eb);
        set_en(1, 1'b1);
        send_bits(32'h0000_00B1, 8, 1'b0);
        set_en(1, 1'b0);
        chk("b_valid_after", valid_b, 1);

        repeat (10) @(negedge clock);
        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_frame_deserializer.md
Name: input_frame_deserializer

Overview:
Successor to the 1-bit serial input loader. Receives one input frame of numInputs pixels, each bitsPerPixel bits wide, over a 3-wire serial link (serialClock, serialData, serialEnable) into the system clock domain. Converts every pixel to signed Qm.n fixed point and presents the whole frame on a double-buffered parallel bus to the first network layer, using a valid/ready handshake.

Parameters:
numInputs, 784, pixels per frame (>=2)
bitsPerPixel, 8, bits per pixel on the link, MSB first (1..dataFracWidth)
dataWidth, 16, width of each output word
dataFracWidth, 8, fractional bits of output word
dataIntWidth, 8, integer bits of output word (dataIntWidth+dataFracWidth == dataWidth)

Ports:
clock  input  1  system clock; all state is on its rising edge
resetN  input  1  asynchronous, active-low reset
serialClock  input  1  link bit clock, asynchronous to clock; sampled, never used as a clock
serialData  input  1  link data, valid at serialClock rising edge
serialEnable  input  1  frame envelope, high for the whole frame
dataReady  input  1  consumer accepts frame
dataOut  output  numInputs*dataWidth  converted frame, pixel i at [dataWidth*i +: dataWidth]
dataValid  output  1  dataOut holds an unconsumed frame
overrun  output  1  sticky: a new frame replaced an unconsumed one
frameAbort  output  1  one-cycle pulse: serialEnable fell mid-frame

Behaviour:
- Reset (resetN low, asynchronous): dataOut=0, dataValid=0, overrun=0, frameAbort=0. Synchronisers, shift register and counters cleared. State = IDLE. Reset mid-frame discards the partial frame.
- serialClock, serialData and serialEnable each pass through a 2-flop synchroniser (s1, s2) plus a history flop (s3). A rise is s2 & ~s3 and a fall is ~s2 & s3. Only synchronised values are used.
- The link requires each serialClock high and low phase to last >=3 clock periods. serialData must be stable from 3 clocks before to 3 clocks after the serialClock rising edge.
- FSM IDLE:
  - On an enable rise, clear bitCnt and pixelCnt, then go to SHIFT.
  - serialClock rises are ignored.
- FSM SHIFT:
  - On each serialClock rise, shift the synchronised serialData into a (numInputs*bitsPerPixel)-bit shift register from the LSB end.
  - bitCnt counts 0..bitsPerPixel-1 and wraps to 0. pixelCnt increments on the wrap.
  - On the rise that completes pixel numInputs-1:
    - load dataOut on that same edge from the shift register including the new bit;
    - set dataValid=1;
    - go to DONE.
  - Enable fall before completion: pulse frameAbort for 1 cycle, leave dataOut and dataValid unchanged, go to IDLE.
  - If the enable fall and the final serialClock rise occur in the same cycle, the frame completes and there is no abort.
- FSM DONE:
  - Extra serialClock rises are ignored.
  - Enable fall goes to IDLE with no abort.
- Pixel ordering:
  - The last pixel received maps to index 0.
  - The first pixel received maps to index numInputs-1.
  - Within a pixel, the first bit received is the MSB.
- Conversion, pixel p unsigned, B=bitsPerPixel, F=dataFracWidth:
  - If p == 2^B-1, output 1.0, i.e. the word with only bit F set.
  - Otherwise output p << (F-B), zero-extended.
  - The result is never negative.
  - For B=1 this yields 0.0/1.0.
- Handshake:
  - dataValid & dataReady on a clock edge clears dataValid on that edge.
  - dataOut holds its value until the next frame load and does not change while dataValid=1 unless overwritten by a new frame.
- Completion while dataValid=1 and no accept in that cycle: dataOut is overwritten, dataValid stays 1, overrun is set.
- Completion in the same cycle as an accept: the new frame loads, dataValid stays 1, overrun is not set.
- overrun clears only on reset.
- Latency: the final bit's serialClock pin rise first sampled at edge k gives dataOut/dataValid updated at edge k+2.

Test Plan:
1. numInputs=4, B=8, send pixels 0xFF,0x80,0x00,0x01, dataReady=0 → dataValid=1; dataOut[3]=0x0100, [2]=0x0080, [1]=0x0000, [0]=0x0001; overrun=0.
2. B=1, numInputs=8, bits 1,0,1,1,0,0,0,1 → words [7..0] = 0x0100,0,0x0100,0x0100,0,0,0,0x0100. Matches the legacy 1-bit loader.
3. First frame left unaccepted, then a second full frame → dataOut shows frame 2, dataValid=1, overrun=1. Repeat after reset with dataReady pulsed on the exact completion edge → dataValid=1, overrun=0.
4. Drop serialEnable after 17 bits (B=8) → frameAbort high for exactly 1 cycle, dataOut and dataValid unchanged. The next full frame loads correctly.
5. Assert resetN=0 mid-frame after 10 bits, release, send a full frame → all outputs 0 during reset; the first frame after reset decodes correctly with no leftover bits.
6. After completion, 5 extra serialClock pulses with enable still high → no change to dataOut, dataValid or overrun. Raise dataReady → dataValid falls on the next edge.
